// File: rtl/lcg_stim_pkg.sv
// Shared types and the LCG step function for the LCG stimulus generator.
// Both rtl/lcg_core.sv and rtl/lcg_stim_gen.sv import this package.
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MULT = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC  = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        DONE
    } state_e;

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * LCG_MULT + LCG_INC;
    endfunction

endpackage

// File: rtl/lcg_core.sv
// 32-bit LCG state register.
// A load has priority over an advance.
module lcg_core
    import lcg_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1188332531
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        adv_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (adv_i) begin
            state_d = next_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign next_o  = lcg_next(state_q);

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG stimulus engine: builds OUT_W-bit vectors from 32-bit LCG chunks.
// Define LCG_STIM_PREFETCH_EN for a shadow buffer giving back-to-back vectors.
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          OUT_W        = 263,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] DEFAULT_SEED = 32'd1188332531
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    output logic             stim_valid,
    input  logic             stim_ready,
    output logic [OUT_W-1:0] stim_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);

    localparam int NCHUNK = (OUT_W + 31) / 32;
    localparam int LASTW  = OUT_W - 32 * (NCHUNK - 1);
    localparam int CW     = $clog2(NCHUNK + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    logic        ld;
    logic [31:0] ld_val;
    logic        adv;
    logic [31:0] lcg_q;
    logic [31:0] lcg_nxt;
    logic        hs;
    logic        last_vec;

    lcg_core #(
        .SEED(DEFAULT_SEED)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ld),
        .load_val_i(ld_val),
        .adv_i     (adv),
        .state_o   (lcg_q),
        .next_o    (lcg_nxt)
    );

    // Chunk k lands at bits [32k+31:32k]; the top chunk is truncated.
    function automatic logic [OUT_W-1:0] put_chunk(
        input logic [OUT_W-1:0] v,
        input logic [CW-1:0]    k,
        input logic [31:0]      w
    );
        logic [OUT_W-1:0] r;
        r = v;
        for (int i = 0; i < NCHUNK - 1; i++) begin
            if (k == CW'(i)) r[i*32 +: 32] = w;
        end
        if (k == CW'(NCHUNK - 1)) r[OUT_W-1 -: LASTW] = w[LASTW-1:0];
        return r;
    endfunction

    assign hs       = stim_valid && stim_ready;
    assign last_vec = (num_vec != '0) && (vcnt_q + 1'b1 == num_vec);

`ifdef LCG_STIM_PREFETCH_EN
    logic [OUT_W-1:0] sh_q, sh_d, sh_nxt;
    logic [CW-1:0]    scnt_q, scnt_d, scnt_nxt;
    logic [31:0]      snap_q, snap_d;
`else
    logic lcg_unused;
    assign lcg_unused = ^lcg_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vcnt_d  = vcnt_q;
        ld      = 1'b0;
        ld_val  = seed_in;
        adv     = 1'b0;
`ifdef LCG_STIM_PREFETCH_EN
        sh_d     = sh_q;
        scnt_d   = scnt_q;
        snap_d   = snap_q;
        sh_nxt   = sh_q;
        scnt_nxt = scnt_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                ld = seed_load;
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    vcnt_d  = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    adv    = 1'b1;
                    data_d = put_chunk(data_q, cnt_q, lcg_nxt);
                    if (cnt_q == CW'(NCHUNK - 1)) begin
                        state_d = PRESENT;
                        cnt_d   = '0;
`ifdef LCG_STIM_PREFETCH_EN
                        snap_d = lcg_nxt;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
`ifdef LCG_STIM_PREFETCH_EN
                if (scnt_q != CW'(NCHUNK)) begin
                    adv      = 1'b1;
                    sh_nxt   = put_chunk(sh_q, scnt_q, lcg_nxt);
                    scnt_nxt = scnt_q + 1'b1;
                end
`endif
                if (hs) begin
                    vcnt_d = (&vcnt_q) ? vcnt_q : vcnt_q + 1'b1;
                end
                if (abort || (hs && last_vec)) begin
                    state_d = DONE;
`ifdef LCG_STIM_PREFETCH_EN
                    // Rewind prefetched steps so runs continue the sequence.
                    ld     = 1'b1;
                    ld_val = snap_q;
                    scnt_d = '0;
`endif
                end else if (hs) begin
`ifdef LCG_STIM_PREFETCH_EN
                    data_d = sh_nxt;
                    scnt_d = '0;
                    if (scnt_nxt == CW'(NCHUNK)) begin
                        state_d = PRESENT;
                        snap_d  = adv ? lcg_nxt : lcg_q;
                    end else begin
                        state_d = FILL;
                        cnt_d   = scnt_nxt;
                    end
`else
                    state_d = FILL;
                    cnt_d   = '0;
`endif
                end
`ifdef LCG_STIM_PREFETCH_EN
                else begin
                    sh_d   = sh_nxt;
                    scnt_d = scnt_nxt;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vcnt_q  <= vcnt_d;
        end
    end

`ifdef LCG_STIM_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            scnt_q <= '0;
            snap_q <= '0;
        end else begin
            sh_q   <= sh_d;
            scnt_q <= scnt_d;
            snap_q <= snap_d;
        end
    end
`endif

    assign stim_valid = (state_q == PRESENT);
    assign busy       = (state_q == FILL) || (state_q == PRESENT);
    assign done       = (state_q == DONE);
    assign stim_data  = data_q;
    assign vec_count  = vcnt_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Bench for lcg_stim_gen: LCG-stream model plus directed scenarios.
// Timing checks assume the default single-buffer build.
module tb_lcg_stim_gen;

    localparam int          W   = 263;
    localparam int          NC  = 9;
    localparam int          SW  = 40;
    localparam logic [31:0] DEF = 32'd1188332531;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          seed_load = 0, start = 0, abort = 0, stim_ready = 0;
    logic [31:0]   seed_in = 0, num_vec = 0;
    logic          stim_valid, busy, done;
    logic [W-1:0]  stim_data;
    logic [31:0]   vec_count;

    logic          s_seed_load = 0, s_start = 0, s_abort = 0, s_ready = 0;
    logic [31:0]   s_seed_in = 0, s_num_vec = 0;
    logic          s_valid, s_busy, s_done;
    logic [SW-1:0] s_data;
    logic [31:0]   s_vcnt;

    int checks = 0;
    int errors = 0;

    lcg_stim_gen #(.OUT_W(W), .CNT_W(32), .DEFAULT_SEED(DEF)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .start(start), .abort(abort), .num_vec(num_vec),
        .stim_valid(stim_valid), .stim_ready(stim_ready),
        .stim_data(stim_data), .busy(busy), .done(done),
        .vec_count(vec_count)
    );

    lcg_stim_gen #(.OUT_W(SW), .CNT_W(32), .DEFAULT_SEED(DEF)) u_small (
        .clk(clk), .rst_n(rst_n), .seed_load(s_seed_load),
        .seed_in(s_seed_in), .start(s_start), .abort(s_abort),
        .num_vec(s_num_vec), .stim_valid(s_valid), .stim_ready(s_ready),
        .stim_data(s_data), .busy(s_busy), .done(s_done),
        .vec_count(s_vcnt)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h3039;
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) s = step(s);
        return s;
    endfunction

    // Vector = NC successive post-step states, chunk 0 lowest.
    function automatic logic [W-1:0] gen(input logic [31:0] s);
        logic [NC*32-1:0] v;
        for (int i = 0; i < NC; i++) begin
            s = step(s);
            v[i*32 +: 32] = s;
        end
        return v[W-1:0];
    endfunction

    // Model: position in the LCG stream, run status and fill progress.
    logic [31:0] m_s;
    bit          m_run, m_done;
    int          m_cnt, m_fill;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_s = DEF; m_run = 0; m_done = 0; m_cnt = 0; m_fill = 0;
        end else begin
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("vec_count", vec_count, m_cnt);
            if (m_run) chk("valid_timing", stim_valid, m_fill == NC);
            else       chk("valid_idle", stim_valid, 0);
            if (stim_valid) chk("data", stim_data, gen(m_s));
            if (!m_run) begin
                if (seed_load) m_s = seed_in;
                if (start) begin
                    m_run = 1; m_done = 0; m_cnt = 0; m_fill = 0;
                end
            end else if (stim_valid && stim_ready) begin
                m_s = adv(m_s, NC);
                m_cnt++;
                m_fill = 0;
                if (abort || (num_vec != 0 && m_cnt == num_vec)) begin
                    m_run = 0; m_done = 1;
                end
            end else if (abort) begin
                m_s = adv(m_s, stim_valid ? NC : m_fill);
                m_run = 0; m_done = 1;
            end else if (!stim_valid) begin
                m_fill++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int budget,
                             input bit rnd);
        int n = 0;
        while (!done && n < budget) begin
            if (rnd) stim_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        chk(nm, done, 1);
    endtask

    task automatic wait_vcnt(input string nm, input int target,
                             input int budget);
        int n = 0;
        while (vec_count < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, vec_count, target);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!stim_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, stim_valid, 1);
    endtask

    task automatic run(input int nv);
        num_vec = nv;
        start = 1;
        tick(1);
        start = 0;
    endtask

    initial begin
        int lat;
        chk("pin_step0", step(32'h0), 32'h0000_3039);
        chk("pin_step1", step(32'h3039), 32'hD3DC_167E);
        tick(3);
        chk("rst_valid", stim_valid, 0);
        chk("rst_data", stim_data, 0);
        chk("rst_vcnt", vec_count, 0);
        chk("rst_small_data", s_data, 0);
        @(posedge clk); #1;
        rst_n = 1;
        tick(2);

        // 1: 40-bit vector from seed 0
        s_seed_load = 1; s_seed_in = 0;
        tick(1);
        s_seed_load = 0; s_num_vec = 1; s_ready = 1; s_start = 1;
        tick(1);
        s_start = 0;
        lat = 1;
        while (!s_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("t1_latency", lat, 3);
        chk("t1_data", s_data, 40'h7E_0000_3039);
        tick(1);
        chk("t1_vcnt", s_vcnt, 1);
        chk("t1_done", s_done, 1);
        chk("t1_valid", s_valid, 0);

        // 2: four vectors from DEFAULT_SEED under random ready
        run(4);
        wait_valid("t2_first", 20);
        chk("t2_vec0", stim_data, gen(DEF));
        wait_done("t2_wait", 600, 1);
        chk("t2_vcnt", vec_count, 4);

        // 3: abort three cycles into vector 2, then restart
        stim_ready = 1;
        run(5);
        wait_vcnt("t3_wait", 1, 40);
        tick(3);
        abort = 1;
        tick(1);
        abort = 0;
        chk("t3_done", done, 1);
        chk("t3_vcnt", vec_count, 1);
        run(2);
        wait_valid("t3_valid", 20);
        chk("t3_cont", stim_data, gen(adv(DEF, 4 * NC + NC + 3)));
        wait_done("t3_wait2", 100, 0);

        // 4: async reset while a vector is presented
        stim_ready = 0;
        run(3);
        wait_valid("t4_valid", 20);
        #2 rst_n = 0;
        #1;
        chk("t4_valid0", stim_valid, 0);
        chk("t4_data0", stim_data, 0);
        chk("t4_busy0", busy, 0);
        chk("t4_vcnt0", vec_count, 0);
        @(posedge clk); #1;
        rst_n = 1;
        tick(1);
        stim_ready = 1;
        run(1);
        wait_valid("t4_valid2", 20);
        chk("t4_seq", stim_data, gen(DEF));
        wait_done("t4_wait", 40, 0);

        // 5: free-run 100 vectors then abort
        run(0);
        wait_vcnt("t5_wait", 100, 2000);
        abort = 1;
        tick(1);
        abort = 0;
        chk("t5_vcnt", vec_count, 100);
        chk("t5_done", done, 1);

        // 6: start and seed_load while busy are ignored
        run(3);
        tick(4);
        start = 1; seed_load = 1; seed_in = 32'hDEAD_BEEF;
        tick(1);
        start = 0; seed_load = 0;
        wait_done("t6_wait", 600, 1);
        chk("t6_vcnt", vec_count, 3);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
